// File: rtl/rom_bus_pkg.sv
// Shared constants for the 4001 ROM bus emulation: phase numbering and I/O opcodes.
// Latency: n/a (constants only).
// Backpressure: n/a.
package rom_bus_pkg;

    // Instruction-cycle phases, one per clock, A1 first after SYNC_N
    localparam logic [2:0] PH_A1 = 3'd0;
    localparam logic [2:0] PH_A2 = 3'd1;
    localparam logic [2:0] PH_A3 = 3'd2;
    localparam logic [2:0] PH_M1 = 3'd3;
    localparam logic [2:0] PH_M2 = 3'd4;
    localparam logic [2:0] PH_X1 = 3'd5;
    localparam logic [2:0] PH_X2 = 3'd6;
    localparam logic [2:0] PH_X3 = 3'd7;

    // I/O instruction group and the two port opcodes this block answers
    localparam logic [3:0] OPR_IO  = 4'hE;
    localparam logic [3:0] OPA_WRR = 4'h2;
    localparam logic [3:0] OPA_RDR = 4'hA;

endpackage

// File: rtl/bus_phase_trk.sv
// Tracks the 8-phase instruction cycle from SYNC_N and flags out-of-place syncs.
// Latency: phase advances one step per clock; sync_err lands in the A1 after the bad sample.
// Backpressure: none, the CPU cycle cannot be stalled.
module bus_phase_trk
    import rom_bus_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sync_n,
    output logic [7:0] ph_oh,
    output logic       sync_err
);

    logic [2:0] phase;
    logic [2:0] phase_nxt;
    logic       synced;
    logic       synced_nxt;
    logic       err_nxt;

    // Next phase: acquire on first sync, wrap after X3, resync on any early sync
    always_comb begin
        phase_nxt  = phase;
        synced_nxt = synced;
        err_nxt    = 1'b0;
        if (!synced) begin
            if (!sync_n) begin
                phase_nxt  = PH_A1;
                synced_nxt = 1'b1;
            end
        end else if (phase == PH_X3) begin
            phase_nxt = PH_A1;
        end else if (!sync_n) begin
            phase_nxt = PH_A1;
            err_nxt   = 1'b1;
        end else begin
            phase_nxt = phase + 3'd1;
        end
    end

    // Phase, lock flag and error pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase    <= PH_A1;
            synced   <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            phase    <= phase_nxt;
            synced   <= synced_nxt;
            sync_err <= err_nxt;
        end
    end

    // One-hot phase, all-zero while unsynced so nothing downstream acts
    assign ph_oh = synced ? (8'd1 << phase) : 8'd0;

endmodule

// File: rtl/rom_bus_ctrl.sv
// 4001-style ROM bus partner: fetch address capture, instruction return, one 4-bit I/O port.
// Latency: mem_req in A3, rdata used in M1 (1 cycle); io_out updates at the end of X2 of a WRR.
// Backpressure: none, memory must answer in exactly one cycle.
module rom_bus_ctrl
    import rom_bus_pkg::*;
#(
    parameter logic [3:0] CHIP_ID = 4'h0
) (
    input  logic        CLK,
    input  logic        RES_N,
    input  logic        SYNC_N,
    input  logic        CM_ROM_N,
    input  logic [3:0]  BUS_I,
    output logic [3:0]  BUS_O,
    output logic        BUS_OE,
    output logic        mem_req,
    output logic [11:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    input  logic [3:0]  io_in,
    output logic [3:0]  io_out,
    output logic        sync_err
);

    logic [7:0] ph_oh;
    logic [3:0] a_lo;
    logic [3:0] a_mid;
    logic [3:0] rom_lo;
    logic       io_cyc;
    logic [3:0] io_opa;
    logic       selected;
    logic       wr_en;
    logic       rd_en;
    logic       unused_x1;

    bus_phase_trk u_trk (
        .clk      (CLK),
        .rst_n    (RES_N),
        .sync_n   (SYNC_N),
        .ph_oh    (ph_oh),
        .sync_err (sync_err)
    );

    // X1 carries no bus activity for the ROM side
    assign unused_x1 = ph_oh[PH_X1];

    // Port access decodes: only the WRR/RDR opcodes of a selected chip act
    assign wr_en = ph_oh[PH_X2] && io_cyc && (io_opa == OPA_WRR) && selected;
    assign rd_en = ph_oh[PH_X2] && io_cyc && (io_opa == OPA_RDR) && selected;

    // Low and middle address nibbles; only the low opcode nibble is needed after M1
    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            a_lo   <= 4'h0;
            a_mid  <= 4'h0;
            rom_lo <= 4'h0;
        end else begin
            if (ph_oh[PH_A1]) a_lo   <= BUS_I;
            if (ph_oh[PH_A2]) a_mid  <= BUS_I;
            if (ph_oh[PH_M1]) rom_lo <= mem_rdata[3:0];
        end
    end

    // I/O cycle marker, latched opcode and SRC chip select
    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            io_cyc   <= 1'b0;
            io_opa   <= 4'h0;
            selected <= 1'b0;
        end else begin
            if (ph_oh[PH_M2]) begin
                io_cyc <= ~CM_ROM_N;
                io_opa <= rom_lo;
            end
            if (ph_oh[PH_X3]) io_cyc <= 1'b0;
            if (ph_oh[PH_X2] && !CM_ROM_N && !io_cyc) selected <= (BUS_I == CHIP_ID);
        end
    end

    // Output port register, loaded by WRR
    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) io_out <= 4'h0;
        else if (wr_en) io_out <= BUS_I;
    end

    // Fetch strobe in A3, high address nibble taken straight off the bus
    always_comb begin
        mem_req  = ph_oh[PH_A3];
        mem_addr = 12'h000;
        if (ph_oh[PH_A3]) mem_addr = {BUS_I, a_mid, a_lo};
    end

    // Bus return: opcode high nibble in M1, low nibble in M2, port pins on RDR
    always_comb begin
        BUS_O  = 4'h0;
        BUS_OE = 1'b0;
        if (ph_oh[PH_M1]) begin
            BUS_O  = mem_rdata[7:4];
            BUS_OE = 1'b1;
        end else if (ph_oh[PH_M2]) begin
            BUS_O  = rom_lo;
            BUS_OE = 1'b1;
        end else if (rd_en) begin
            BUS_O  = io_in;
            BUS_OE = 1'b1;
        end
    end

endmodule

// File: tb/tb_rom_bus_ctrl.sv
// Bench for rom_bus_ctrl: phase-by-phase stimulus with expected outputs queued per cycle.
// Latency: expectations are checked 2 time units after each driving negedge.
// Backpressure: n/a.
module tb_rom_bus_ctrl;
    import rom_bus_pkg::*;

    localparam logic [3:0] CID = 4'h5;

    logic        CLK;
    logic        RES_N;
    logic        SYNC_N;
    logic        CM_ROM_N;
    logic [3:0]  BUS_I;
    logic [3:0]  BUS_O;
    logic        BUS_OE;
    logic        mem_req;
    logic [11:0] mem_addr;
    logic [7:0]  mem_rdata = 8'h00;
    logic [3:0]  io_in;
    logic [3:0]  io_out;
    logic        sync_err;

    logic [7:0]  rom_next = 8'h00;
    int          n_cmp = 0;
    int          n_bad = 0;

    typedef struct packed {
        logic        oe;
        logic [3:0]  bo;
        logic        req;
        logic [11:0] addr;
        logic [3:0]  io;
        logic        err;
    } exp_t;

    exp_t  sb[$];
    string nq[$];

    rom_bus_ctrl #(.CHIP_ID(CID)) dut (
        .CLK       (CLK),
        .RES_N     (RES_N),
        .SYNC_N    (SYNC_N),
        .CM_ROM_N  (CM_ROM_N),
        .BUS_I     (BUS_I),
        .BUS_O     (BUS_O),
        .BUS_OE    (BUS_OE),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .io_in     (io_in),
        .io_out    (io_out),
        .sync_err  (sync_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Program memory: answers a request one cycle later, zero otherwise
    always @(posedge CLK) mem_rdata <= mem_req ? rom_next : 8'h00;

    // Scoreboard: pop the expectation for the current cycle and compare
    always @(negedge CLK) begin : mon
        exp_t  e;
        string nm;
        #2;
        if (sb.size() > 0) begin
            e  = sb.pop_front();
            nm = nq.pop_front();
            n_cmp += 6;
            if (BUS_OE !== e.oe) begin n_bad++; $display("FAIL %s bus_oe: got %b want %b", nm, BUS_OE, e.oe); end
            if (BUS_O !== e.bo) begin n_bad++; $display("FAIL %s bus_o: got %h want %h", nm, BUS_O, e.bo); end
            if (mem_req !== e.req) begin n_bad++; $display("FAIL %s mem_req: got %b want %b", nm, mem_req, e.req); end
            if (mem_addr !== e.addr) begin n_bad++; $display("FAIL %s mem_addr: got %h want %h", nm, mem_addr, e.addr); end
            if (io_out !== e.io) begin n_bad++; $display("FAIL %s io_out: got %h want %h", nm, io_out, e.io); end
            if (sync_err !== e.err) begin n_bad++; $display("FAIL %s sync_err: got %b want %b", nm, sync_err, e.err); end
        end
    end

    // Drive one cycle of inputs and queue what the outputs must be in that cycle
    task automatic drive(input logic rn, input logic s_n, input logic cm, input logic [3:0] bi,
                         input logic [3:0] ioi, input string nm, input logic e_oe, input logic [3:0] e_bo,
                         input logic e_req, input logic [11:0] e_addr, input logic [3:0] e_io, input logic e_err);
        exp_t e;
        @(negedge CLK);
        RES_N = rn; SYNC_N = s_n; CM_ROM_N = cm; BUS_I = bi; io_in = ioi;
        e.oe = e_oe; e.bo = e_bo; e.req = e_req; e.addr = e_addr; e.io = e_io; e.err = e_err;
        sb.push_back(e);
        nq.push_back(nm);
    endtask

    // One instruction cycle from A1; SYNC_N low at sync_at (8 = never), stop after last_ph
    task automatic instr(input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] a3, input logic [7:0] rom,
                         input logic cm_m2, input logic cm_x2, input logic [3:0] bi_x2, input logic [3:0] ioi,
                         input logic x2_oe, input logic [3:0] x2_bo, input logic [3:0] io_b, input logic [3:0] io_a,
                         input logic err_a1, input int sync_at, input int last_ph, input string tag);
        for (int p = 0; p <= last_ph; p++) begin
            logic        cm;
            logic [3:0]  bi;
            logic        e_oe;
            logic [3:0]  e_bo;
            logic        e_req;
            logic [11:0] e_addr;
            logic [3:0]  e_io;
            logic        e_err;
            cm = 1'b1; bi = 4'h0; e_oe = 1'b0; e_bo = 4'h0; e_req = 1'b0; e_addr = 12'h000;
            e_io = io_b; e_err = 1'b0;
            case (p)
                0: begin bi = a1; e_err = err_a1; end
                1: bi = a2;
                2: begin bi = a3; e_req = 1'b1; e_addr = {a3, a2, a1}; rom_next = rom; end
                3: begin e_oe = 1'b1; e_bo = rom[7:4]; end
                4: begin cm = cm_m2; e_oe = 1'b1; e_bo = rom[3:0]; end
                6: begin cm = cm_x2; bi = bi_x2; e_oe = x2_oe; e_bo = x2_bo; end
                7: e_io = io_a;
                default: ;
            endcase
            drive(1'b1, (p == sync_at) ? 1'b0 : 1'b1, cm, bi, ioi, $sformatf("%s.ph%0d", tag, p),
                  e_oe, e_bo, e_req, e_addr, e_io, e_err);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++)
            drive(1'b0, 1'b0, 1'b0, 4'hF, 4'hF, "reset", 1'b0, 4'h0, 1'b0, 12'h000, 4'h0, 1'b0);
    endtask

    task automatic test_sync_acq();
        for (int i = 0; i < 3; i++)
            drive(1'b1, 1'b1, 1'b1, 4'hF, 4'h0, "unsynced", 1'b0, 4'h0, 1'b0, 12'h000, 4'h0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 4'hF, 4'h0, "first_sync", 1'b0, 4'h0, 1'b0, 12'h000, 4'h0, 1'b0);
        instr(4'h1, 4'h2, 4'h3, 8'h40, 1'b1, 1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 8, 7, "acq_x3high");
        instr(4'hE, 4'hD, 4'hC, 8'hB1, 1'b1, 1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 7, 7, "acq_wrap");
    endtask

    task automatic test_fetch();
        instr(4'h5, 4'hA, 4'h3, 8'hD7, 1'b1, 1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 7, 7, "fetch_3a5");
        instr(4'hF, 4'h0, 4'hC, 8'h3E, 1'b1, 1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 7, 7, "fetch_c0f");
    endtask

    task automatic test_write_sel();
        instr(4'h0, 4'h1, 4'h0, 8'h21, 1'b1, 1'b0, CID, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 7, 7, "src_sel");
        instr(4'h1, 4'h1, 4'h0, {OPR_IO, OPA_WRR}, 1'b0, 1'b1, 4'h9, 4'h0, 1'b0, 4'h0, 4'h0, 4'h9, 1'b0, 7, 7, "wrr_sel");
        instr(4'h2, 4'h1, 4'h0, 8'h00, 1'b1, 1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 4'h9, 4'h9, 1'b0, 7, 7, "after_wrr");
    endtask

    task automatic test_write_desel();
        instr(4'h3, 4'h1, 4'h0, 8'h21, 1'b1, 1'b0, CID + 4'h1, 4'h0, 1'b0, 4'h0, 4'h9, 4'h9, 1'b0, 7, 7, "src_desel");
        instr(4'h4, 4'h1, 4'h0, {OPR_IO, OPA_WRR}, 1'b0, 1'b1, 4'h4, 4'h0, 1'b0, 4'h0, 4'h9, 4'h9, 1'b0, 7, 7, "wrr_desel");
    endtask

    task automatic test_rdr();
        instr(4'h5, 4'h1, 4'h0, 8'h21, 1'b1, 1'b0, CID, 4'h6, 1'b0, 4'h0, 4'h9, 4'h9, 1'b0, 7, 7, "src_rdr");
        instr(4'h6, 4'h1, 4'h0, {OPR_IO, OPA_RDR}, 1'b0, 1'b1, 4'h0, 4'h6, 1'b1, 4'h6, 4'h9, 4'h9, 1'b0, 7, 7, "rdr");
        instr(4'h7, 4'h1, 4'h0, {OPR_IO, 4'h0}, 1'b0, 1'b1, 4'h5, 4'h6, 1'b0, 4'h0, 4'h9, 4'h9, 1'b0, 7, 7, "wrm_ignored");
    endtask

    task automatic test_errors();
        instr(4'h1, 4'h2, 4'h3, 8'h5C, 1'b1, 1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 4'h9, 4'h9, 1'b0, 4, 4, "sync_in_m2");
        instr(4'h4, 4'h5, 4'h6, 8'h9B, 1'b1, 1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 4'h9, 4'h9, 1'b1, 7, 7, "resync");
        instr(4'h8, 4'h9, 4'hA, 8'h12, 1'b1, 1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 4'h9, 4'h9, 1'b0, 7, 7, "post_resync");
    endtask

    task automatic test_reset_midcycle();
        instr(4'h7, 4'h8, 4'h9, 8'hC3, 1'b1, 1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 4'h9, 4'h9, 1'b0, 8, 4, "pre_reset");
        drive(1'b0, 1'b1, 1'b1, 4'h0, 4'h0, "reset_x1", 1'b0, 4'h0, 1'b0, 12'h000, 4'h0, 1'b0);
        for (int i = 0; i < 8; i++)
            drive(1'b1, 1'b1, 1'b0, 4'(i), 4'hF, "post_reset_idle", 1'b0, 4'h0, 1'b0, 12'h000, 4'h0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 4'h0, 4'h0, "post_reset_sync", 1'b0, 4'h0, 1'b0, 12'h000, 4'h0, 1'b0);
        instr(4'h2, 4'h4, 4'h8, 8'h6E, 1'b1, 1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 7, 7, "relock");
    endtask

    initial begin
        RES_N = 1'b0; SYNC_N = 1'b1; CM_ROM_N = 1'b1; BUS_I = 4'h0; io_in = 4'h0;
        test_reset();
        test_sync_acq();
        test_fetch();
        test_write_sel();
        test_write_desel();
        test_rdr();
        test_errors();
        test_reset_midcycle();
        @(negedge CLK);
        #3;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rom_bus_ctrl.md
# rom_bus_ctrl

FPGA-side emulation of the 4001 ROM bus partner for the CPU core: tracks the 8-phase instruction cycle from `SYNC_N`, assembles the 12-bit fetch address from the A1–A3 nibbles, and drives the fetched byte back in M1/M2. It also implements one 4001-style 4-bit I/O port, selected by SRC and written or read by WRR/RDR. It sits between the core's `DATA_O`/`DATA_OE`/`CM_ROM_N`/`SYNC_N` pins and a synchronous program memory.

## Interface
- `CHIP_ID`, default 4'h0: SRC high-nibble value that selects this block's I/O port.
- `CLK` in 1: single system clock, the same clock as the CPU core.
- `RES_N` in 1: asynchronous, active-low reset.
- `SYNC_N` in 1: CPU sync, low during X3.
- `CM_ROM_N` in 1: CPU ROM command line, active low.
- `BUS_I` in 4: CPU `DATA_O`.
- `BUS_O` out 4: nibble sent to CPU `DATA_I`.
- `BUS_OE` out 1: this block drives the bus.
- `mem_req` out 1: read strobe, one cycle.
- `mem_addr` out 12: read address, valid while `mem_req` is high.
- `mem_rdata` in 8: read data, valid exactly 1 cycle after `mem_req`.
- `io_in` in 4: port input pins.
- `io_out` out 4: registered port output.
- `sync_err` out 1: one-cycle pulse on an unexpected `SYNC_N`.

## Operation
- **Phase tracker.** Holds a 3-bit phase (A1=0 … X3=7) plus a `synced` flag.
  - Reset: `synced`=0.
  - `SYNC_N` sampled low while unsynced: next phase is A1 and `synced`=1.
  - While synced: phase increments every clock and wraps X3→A1.
  - `SYNC_N` low in any phase other than X3: resync so the next phase is A1, and pulse `sync_err`.
  - `SYNC_N` high in X3: no error; the wrap is unconditional.
- **Address capture.**
  - End of A1: `BUS_I` → `a_lo`.
  - End of A2: `BUS_I` → `a_mid`.
  - During A3: `mem_addr` = {`BUS_I`, `a_mid`, `a_lo`} (combinational from `BUS_I`) and `mem_req`=1. Both are gated by `synced`.
- **Instruction return.**
  - M1: `BUS_O` = `mem_rdata[7:4]`.
  - End of M1: `mem_rdata` → `rom_byte`.
  - M2: `BUS_O` = `rom_byte[3:0]`.
  - `BUS_OE`=1 during M1 and M2 whenever synced.
- **I/O decode.**
  - End of M2: `io_cyc` ← ~`CM_ROM_N`, `io_opa` ← `rom_byte[3:0]`.
  - `io_cyc` is cleared at the end of X3.
- **SRC.** In X2 with `CM_ROM_N`=0 and `io_cyc`=0: `selected` ← (`BUS_I` == `CHIP_ID`).
- **WRR.** In X2 with `io_cyc`=1, `io_opa`=4'h2 and `selected`=1: `io_out` ← `BUS_I` at the end of X2.
- **RDR.** In X2 with `io_cyc`=1, `io_opa`=4'hA and `selected`=1: `BUS_O` = `io_in` and `BUS_OE`=1.
- **Other I/O opcodes** (RAM-side ones) are ignored. The bus is not driven and `io_out` is unchanged.
- **Idle bus.** `BUS_O`=0 whenever `BUS_OE`=0.
- **Reset values.**
  - Outputs: `BUS_O`=0, `BUS_OE`=0, `mem_req`=0, `mem_addr`=0, `io_out`=0, `sync_err`=0.
  - Internal: `selected`=0, `io_cyc`=0, `synced`=0.
  - Reset asserted mid-cycle aborts the cycle. Nothing is driven until the next `SYNC_N` after release.

## Timing
- All state updates on `posedge CLK`; the block has one phase per clock.
- `mem_req` → `mem_rdata`: fixed latency of 1 cycle. There is no stall, because the CPU cannot wait.
- `BUS_O`/`BUS_OE` are combinational from registered phase, `mem_rdata`, `rom_byte` and `io_in`, and are valid within the phase cycle.
- `io_out` updates on the clock edge that ends X2 of a WRR.
- `sync_err` is asserted in the cycle after the offending `SYNC_N` sample, the same cycle in which phase = A1.

## Structure
- Package `rom_bus_pkg` holds:
  - the phase localparams `PH_A1`…`PH_X3`;
  - the opcode constants `OPR_IO`=4'hE, `OPA_WRR`=4'h2, `OPA_RDR`=4'hA.
- Sub-module `bus_phase_trk` implements the phase counter, the `synced` flag and `sync_err`. It outputs a one-hot phase vector.

## Test plan
1. **Sync acquisition.** After reset, drive 3 cycles with `SYNC_N`=1 → `BUS_OE`=0 and `mem_req`=0. Pulse `SYNC_N` low → next cycle is A1, and exactly 8 cycles later the block is in A1 again.
2. **Fetch.** A1/A2/A3 nibbles 5, A, 3 → `mem_req`=1 in A3 with `mem_addr`=12'h3A5. With `mem_rdata`=8'hD7 → `BUS_O`=4'hD with OE in M1, then `BUS_O`=4'h7 with OE in M2.
3. **Write select.** SRC X2 with `BUS_I`=`CHIP_ID` and `CM_ROM_N`=0, then a fetch of 8'hE2 with `CM_ROM_N`=0 in M2 and `BUS_I`=4'h9 in X2 → `io_out`=4'h9 from the cycle after X2.
4. **Write deselected.** SRC with `BUS_I`=`CHIP_ID`+1, then WRR with 4'h4 → `io_out` unchanged. Before and during that WRR's X2, `BUS_OE`=0 except in M1/M2.
5. **RDR.** Selected, `io_in`=4'h6, fetch 8'hEA with `CM_ROM_N`=0 in M2 → `BUS_O`=4'h6 and `BUS_OE`=1 in X2 only.
6. **Errors and reset.** `SYNC_N` low in phase M2 → `sync_err` pulses once and the next phase is A1. Assert `RES_N` low in X1 → all outputs return to 0 immediately, and the bus stays undriven until the next `SYNC_N`.
